// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
//   Shared types and constants for the truth-table sweeper.
//   - TT_WIDTH  : number of rows in a 3-input truth table (8)
//   - IDX_WIDTH : width of the row index / driven vector (3)
//   - tt_state_t: sweeper FSM state encoding (also exported for debug)
//   - sampled_mask(): bit mask of the rows already sampled up to an index,
//                     in Wolfram order (row i lives in bit 7-i)
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

  localparam int TT_WIDTH  = 8;
  localparam int IDX_WIDTH = 3;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TT_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } tt_state_t;

  // Rows 0..idx occupy bits 7 down to 7-idx, so the mask is all-ones
  // shifted left by the number of rows not yet visited.
  function automatic logic [TT_WIDTH-1:0] sampled_mask(input logic [IDX_WIDTH-1:0] idx);
    logic [TT_WIDTH-1:0] ones;
    ones = '1;
    return ones << (LAST_IDX - idx);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
//   Bundles the control/result signals of the truth-table sweeper.
//
//   Handshake: start is a one-cycle request pulse that is honoured only
//   while the sweeper is idle (busy=0, done=0); any other start is dropped.
//   busy is high for the whole sweep, and done is a one-cycle completion
//   pulse during which busy is already low. pass/measured/mismatch are
//   valid from done until the next accepted start.
//
//   Signals:
//     start     requester -> sweeper  begin a sweep (pulse)
//     expected  requester -> sweeper  golden table, Wolfram order
//     dut_out   gate      -> sweeper  gate output, synchronous to clk
//     drv       sweeper   -> gate     {in1,in2,in3} applied to the gate
//     busy      sweeper   -> requester sweep in progress
//     done      sweeper   -> requester sweep finished (pulse)
//     pass      sweeper   -> requester measured == expected
//     measured  sweeper   -> requester sampled table, Wolfram order
//     mismatch  sweeper   -> requester measured ^ expected
//     dbg_state sweeper   -> observer  current FSM state
//
//   Modports: master = requester/gate side, slave = sweeper.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if;
  import tt_sweep_pkg::*;

  logic                 start;
  logic [TT_WIDTH-1:0]  expected;
  logic                 dut_out;
  logic [IDX_WIDTH-1:0] drv;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [TT_WIDTH-1:0]  measured;
  logic [TT_WIDTH-1:0]  mismatch;
  tt_state_t            dbg_state;

  modport master (
    output start, expected, dut_out,
    input  drv, busy, done, pass, measured, mismatch, dbg_state
  );

  modport slave (
    input  start, expected, dut_out,
    output drv, busy, done, pass, measured, mismatch, dbg_state
  );

endinterface

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
//   Loadable down-counter with a zero flag. Used to hold each driven
//   vector for a fixed number of cycles before the gate output is sampled.
//
//   Ports:
//     clk, rst    clock, asynchronous active-high reset (count -> 0)
//     load        load load_value this cycle (wins over en)
//     load_value  value to load
//     en          decrement by one; saturates at zero
//     zero        count == 0
// -----------------------------------------------------------------------------
module tt_settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Applies all 8 input vectors to a 3-input gate, holds each vector for
//   SETTLE_CYCLES cycles, samples the gate output, and compares the
//   resulting truth table with a golden table captured at start.
//
//   Per row the FSM spends DRIVE (1) + SETTLE (SETTLE_CYCLES) + SAMPLE (1)
//   cycles; one DONE cycle follows the last row.
//
//   Parameters:
//     SETTLE_CYCLES  1..255, cycles a vector is held before sampling
//
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-high reset
//     bus   truth_table_sweeper_if.slave (start/expected/dut_out in,
//           drv/busy/done/pass/measured/mismatch/dbg_state out)
//
//   Build option:
//     TT_ABORT_ON_FAIL_EN  stop at the first sampled row that disagrees
//                          with the golden table; only rows actually
//                          sampled contribute to measured/mismatch.
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_sweeper_if.slave bus
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  tt_state_t            state;
  tt_state_t            state_next;

  logic [IDX_WIDTH-1:0] idx;
  logic [TT_WIDTH-1:0]  exp_cap;
  logic [TT_WIDTH-1:0]  measured_q;
  logic [TT_WIDTH-1:0]  mismatch_q;
  logic                 pass_q;

  logic [TT_WIDTH-1:0]  measured_next;
  logic [TT_WIDTH-1:0]  mismatch_next;
  logic                 pass_next;
  logic                 abort_hit;
  logic                 last_sample;

  logic                 tmr_load;
  logic                 tmr_en;
  logic                 tmr_zero;

  // ---------------------------------------------------------------------------
  // Settle timer: loaded in DRIVE with SETTLE_CYCLES-1 so SETTLE lasts
  // exactly SETTLE_CYCLES cycles (counts SETTLE_CYCLES-1 down to 0).
  // ---------------------------------------------------------------------------
  tt_settle_timer #(
    .WIDTH (8)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (SETTLE_LOAD),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  // ---------------------------------------------------------------------------
  // Sample-path datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    measured_next = measured_q;
    measured_next[LAST_IDX - idx] = bus.dut_out;
  end

`ifdef TT_ABORT_ON_FAIL_EN
  assign abort_hit = (bus.dut_out != exp_cap[LAST_IDX - idx]);
`else
  assign abort_hit = 1'b0;
`endif

  // The index never wraps: row 7 always ends the sweep.
  assign last_sample = (idx == LAST_IDX) || abort_hit;

  // Rows beyond the current index were never sampled (only possible on an
  // early abort) and must not show up as mismatches.
  assign mismatch_next = (measured_next ^ exp_cap) & sampled_mask(idx);
  assign pass_next     = (mismatch_next == '0);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        tmr_load   = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        state_next = last_sample ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        // start is not looked at here; the next IDLE cycle accepts it.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. idx doubles as the driven vector: it only moves on
  // the transitions into DRIVE, so drv is stable for the whole row.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      exp_cap    <= '0;
      measured_q <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && bus.start) begin
        idx        <= '0;
        exp_cap    <= bus.expected;
        measured_q <= '0;
        mismatch_q <= '0;
        pass_q     <= 1'b0;
      end
      if (state == ST_SAMPLE) begin
        measured_q <= measured_next;
        if (last_sample) begin
          // Registered here so the result is visible in the DONE cycle.
          mismatch_q <= mismatch_next;
          pass_q     <= pass_next;
        end else begin
          idx <= idx + IDX_WIDTH'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.drv       = idx;
  assign bus.busy      = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.measured  = measured_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, range 1..255: cycles the driven input vector is held before sampling.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a sweep; ignored unless idle.
REQ-005 SHALL have port expected, input, 8: golden table in Wolfram order (bit 7-i = output for input i); captured at accepted start.
REQ-006 SHALL have port drv, output, 3: vector {in1,in2,in3} driven to the 3-input gate under test.
REQ-007 SHALL have port dut_out, input, 1: gate output, already synchronous to clk.
REQ-008 SHALL have port busy, output, 1: high from the cycle after accepted start until done asserts.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at sweep end.
REQ-010 SHALL have port pass, output, 1: measured == captured expected; valid from done until the next accepted start.
REQ-011 SHALL have port measured, output, 8: sampled table, Wolfram order.
REQ-012 SHALL have port mismatch, output, 8: measured XOR captured expected.

Function
REQ-013 SHALL implement FSM IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
REQ-014 IDLE: on start=1, capture expected, clear measured/mismatch/pass, set index i=0, go to DRIVE.
REQ-015 DRIVE: drv=i for one cycle, then load settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-016 SETTLE: hold drv; decrement counter; go to SAMPLE when counter reaches 0.
REQ-017 SAMPLE: write measured[7-i]=dut_out; if i==7 go to DONE, else i=i+1 and go to DRIVE.
REQ-018 drv SHALL stay stable from DRIVE through SAMPLE of the same index; it changes only on DRIVE entry.
REQ-019 DONE: done=1 for one cycle; pass and mismatch update in the same cycle; then go to IDLE.
REQ-020 Sweep latency from start to done SHALL be exactly 8*(SETTLE_CYCLES+2)+2 cycles.
REQ-021 The 3-bit index SHALL never wrap; i==7 terminates the sweep.
REQ-022 start while busy SHALL be ignored and SHALL NOT restart or corrupt the sweep.
REQ-023 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-024 measured and mismatch SHALL hold their last values in IDLE until the next accepted start.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, i=0, drv=3'b000, busy=0, done=0, pass=0, measured=0, mismatch=0, and clear captured expected and settle counter.
REQ-026 rst asserted mid-sweep SHALL abort with no done pulse; the first accepted start after release SHALL begin a full sweep.

Configuration
REQ-027 Macro TT_ABORT_ON_FAIL_EN: when defined, the first SAMPLE where dut_out != expected[7-i] SHALL go straight to DONE with pass=0; unsampled measured bits stay 0, and mismatch covers only sampled indices.
REQ-028 Without TT_ABORT_ON_FAIL_EN, all 8 combinations SHALL always be swept, with latency per REQ-020.

Structure
REQ-029 Package tt_sweep_pkg SHALL hold the FSM state enum, TT_WIDTH=8, and IDX_WIDTH=3.
REQ-030 Sub-module tt_settle_timer SHALL implement the loadable down-counter with a zero flag; the FSM SHALL stay in truth_table_sweeper.

Verification
REQ-031 Gate model for rule 0xBA, expected=8'hBA, SETTLE_CYCLES=4 -> done at cycle 50 after start; measured=8'hBA; pass=1; mismatch=0.
REQ-032 Same gate, expected=8'hBB -> pass=0; mismatch=8'h01; measured=8'hBA.
REQ-033 start pulsed again at cycles 10 and 30 of a sweep -> exactly one done at cycle 50; result unchanged.
REQ-034 rst asserted at cycle 20 of a sweep -> all outputs 0 in the same cycle; no done; a new start gives a normal full sweep.
REQ-035 TT_ABORT_ON_FAIL_EN, dut_out tied 0, expected=8'hBA -> done after first SAMPLE (cycle 8); pass=0; mismatch=8'h80; measured=0.
REQ-036 Check drv sequence 0..7 in order; each value held exactly SETTLE_CYCLES+2 cycles.
